// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button hours/minutes editor with synchronized, debounced inputs and an idle timeout.
// Define TSC_AUTOREPEAT_EN to add auto-repeat on a held inc button.

module tsc_debounce #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The level flips only after DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

module time_set_ctrl #(
    parameter int DB_CYCLES  = 20000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000,
    parameter int TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1Hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    output logic       load,
    output logic [7:0] load_hours,
    output logic [7:0] load_minutes,
    output logic [1:0] adj_mode,
    output logic       pause,
    output logic       blink
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET_H = 2'd1,
        S_SET_M = 2'd2
    } state_t;

    localparam int IW = $clog2(TIMEOUT_S + 1);

    logic          w_mode_lvl;
    logic          w_inc_lvl;
    logic          r_mode_lvl_q;
    logic          r_inc_lvl_q;
    logic          r_mode_press;
    logic          r_inc_press;
    logic          w_mode_evt;
    logic          w_inc_evt;
    logic          w_editing;
    logic          w_timeout;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_shadow_h;
    logic [7:0]    r_shadow_m;
    logic [7:0]    w_shadow_h_nxt;
    logic [7:0]    w_shadow_m_nxt;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle_nxt;
    logic          r_load;
    logic          w_load_nxt;
    logic          r_pause;
    logic          w_pause_nxt;
    logic          r_blink;
    logic          w_blink_nxt;
    logic [7:0]    r_load_h;
    logic [7:0]    r_load_m;

    tsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_mode),
        .o_level (w_mode_lvl)
    );

    tsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_inc),
        .o_level (w_inc_lvl)
    );

    // Registered rising-edge pulses: the press event lands DB_CYCLES+3 cycles after a clean raw edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_lvl_q <= 1'b0;
            r_inc_lvl_q  <= 1'b0;
            r_mode_press <= 1'b0;
            r_inc_press  <= 1'b0;
        end else begin
            r_mode_lvl_q <= w_mode_lvl;
            r_inc_lvl_q  <= w_inc_lvl;
            r_mode_press <= w_mode_lvl & ~r_mode_lvl_q;
            r_inc_press  <= w_inc_lvl & ~r_inc_lvl_q;
        end
    end

`ifdef TSC_AUTOREPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_phase;
    logic          w_rpt_evt;

    // Phase 0 waits out the initial delay after the press; phase 1 paces the repeats.
    assign w_rpt_evt = w_inc_lvl &&
                       ((!r_rpt_phase && (r_rpt_cnt == RW'(RPT_DELAY))) ||
                        ( r_rpt_phase && (r_rpt_cnt == RW'(RPT_PERIOD))));

    always_ff @(posedge clk) begin
        if (rst || !w_inc_lvl) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (r_inc_press) begin
            r_rpt_cnt   <= RW'(1);
            r_rpt_phase <= 1'b0;
        end else if (w_rpt_evt) begin
            r_rpt_cnt   <= RW'(1);
            r_rpt_phase <= 1'b1;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end

    assign w_inc_evt = r_inc_press | w_rpt_evt;
`else
    assign w_inc_evt = r_inc_press;
`endif

    assign w_mode_evt = r_mode_press;
    assign w_editing  = (r_state == S_SET_H) || (r_state == S_SET_M);
    assign w_timeout  = w_editing && (r_idle >= IW'(TIMEOUT_S));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A mode press takes priority over the idle timeout, so a commit is never lost.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_mode_evt) w_state_nxt = S_SET_H;
            end
            S_SET_H: begin
                if (w_mode_evt)     w_state_nxt = S_SET_M;
                else if (w_timeout) w_state_nxt = S_RUN;
            end
            S_SET_M: begin
                if (w_mode_evt)     w_state_nxt = S_RUN;
                else if (w_timeout) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_shadow_h_nxt = r_shadow_h;
        w_shadow_m_nxt = r_shadow_m;
        w_load_nxt     = (r_state == S_SET_M) && w_mode_evt;
        w_pause_nxt    = (w_state_nxt != S_RUN);

        if ((r_state == S_RUN) && w_mode_evt) begin
            w_shadow_h_nxt = cur_hours;
            w_shadow_m_nxt = cur_minutes;
        end else if (!w_mode_evt && w_inc_evt) begin
            if (r_state == S_SET_H)
                w_shadow_h_nxt = (r_shadow_h >= 8'd23) ? 8'd0 : r_shadow_h + 8'd1;
            else if (r_state == S_SET_M)
                w_shadow_m_nxt = (r_shadow_m >= 8'd59) ? 8'd0 : r_shadow_m + 8'd1;
        end

        w_idle_nxt = r_idle;
        if ((w_state_nxt != r_state) || w_mode_evt || w_inc_evt)
            w_idle_nxt = '0;
        else if (tick_1Hz && w_editing)
            w_idle_nxt = r_idle + 1'b1;

        w_blink_nxt = r_blink;
        if (w_state_nxt == S_RUN)
            w_blink_nxt = 1'b0;
        else if (w_state_nxt != r_state)
            w_blink_nxt = 1'b1;
        else if (tick_1Hz)
            w_blink_nxt = ~r_blink;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_h <= 8'd0;
            r_shadow_m <= 8'd0;
            r_idle     <= '0;
            r_load     <= 1'b0;
            r_pause    <= 1'b0;
            r_blink    <= 1'b0;
            r_load_h   <= 8'd0;
            r_load_m   <= 8'd0;
        end else begin
            r_shadow_h <= w_shadow_h_nxt;
            r_shadow_m <= w_shadow_m_nxt;
            r_idle     <= w_idle_nxt;
            r_load     <= w_load_nxt;
            r_pause    <= w_pause_nxt;
            r_blink    <= w_blink_nxt;
            if (w_load_nxt) begin
                r_load_h <= r_shadow_h;
                r_load_m <= r_shadow_m;
            end
        end
    end

    assign load         = r_load;
    assign load_hours   = r_load_h;
    assign load_minutes = r_load_m;
    assign adj_mode     = r_state;
    assign pause        = r_pause;
    assign blink        = r_blink;

endmodule
